mio_bus_ctrl: RTL and testbench

- Parametrised, registered successor to the flat combinational MIO decoder.
- Sits between the CPU data port and NSLV memory-mapped slaves (data RAM, GPIO, counter, PS/2 keyboard, ...).
- Decodes `cpu_addr[31:28]` against a per-slot tag table and routes each access to one slave.
- Runs a req/ready handshake with per-slave acknowledge, so slaves may insert wait states; unmapped regions return a bus error instead of silent zero.

---
 rtl/mio_bus_pkg.sv | 19 +
 rtl/mio_addr_decode.sv | 40 ++++
 rtl/mio_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the MIO bus controller.
// Optional feature macro used by the controller: MIO_BUS_TIMEOUT_EN.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default region tags, compared against cpu_addr[31:28]
  localparam logic [3:0] TAG_RAM   = 4'h0;
  localparam logic [3:0] TAG_PS2   = 4'hd;
  localparam logic [3:0] TAG_GPIOE = 4'he;
  localparam logic [3:0] TAG_GPIOF = 4'hf;

  localparam int DW_DEF = 32;

endpackage

// File: rtl/mio_addr_decode.sv
// Region decoder: compares an address tag against the per-slot tag table,
// lowest slot index wins when several slots share a tag.
module mio_addr_decode
  import mio_bus_pkg::*;
#(
  parameter int                NSLV     = 4,
  parameter int                IW       = (NSLV > 1) ? $clog2(NSLV) : 1,
  parameter logic [4*NSLV-1:0] SLOT_TAG = {TAG_GPIOF, TAG_GPIOE, TAG_PS2, TAG_RAM}
) (
  input  logic [3:0]      tag,
  output logic            hit,
  output logic [IW-1:0]   idx,
  output logic [NSLV-1:0] onehot
);

  logic [NSLV-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_match
      assign match[gi] = (tag == SLOT_TAG[4*gi +: 4]);
    end
  endgenerate

  // Walk from the top down so the lowest matching slot is the last to overwrite
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit       = 1'b1;
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered MIO bus controller: decodes the CPU address region, runs a
// req/ack handshake with the selected slave. Optional MIO_BUS_TIMEOUT_EN adds a wait limit.
module mio_bus_ctrl
  import mio_bus_pkg::*;
#(
  parameter int                NSLV        = 4,
  parameter int                DW          = DW_DEF,
  parameter int                AW          = 13,
  parameter logic [4*NSLV-1:0] SLOT_TAG    = {TAG_GPIOF, TAG_GPIOE, TAG_PS2, TAG_RAM},
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_ready,
  output logic             cpu_err,
  output logic [NSLV-1:0]  slv_sel,
  output logic             slv_we,
  output logic [AW-1:0]    slv_addr,
  output logic [DW-1:0]    slv_wdata,
  input  logic [NSLV*DW-1:0] slv_rdata,
  input  logic [NSLV-1:0]  slv_ack
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  generate
    if (NSLV < 1 || NSLV > 8) begin : g_bad_nslv
      $error("mio_bus_ctrl: NSLV=%0d outside 1..8", NSLV);
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
      $error("mio_bus_ctrl: TIMEOUT_CYC=%0d does not fit the 8-bit wait counter", TIMEOUT_CYC);
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [NSLV-1:0] sel_reg, sel_next;
  logic            we_reg, we_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [DW-1:0]   rdata_reg, rdata_next;
  logic            err_reg, err_next;
`ifdef MIO_BUS_TIMEOUT_EN
  logic [7:0]      wait_reg, wait_next;
`endif

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [NSLV-1:0] dec_onehot;
  logic            ack_sel;

  // Address bits below the word offset and above the slave window are not decoded
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[27:AW+2], cpu_addr[1:0]};

  mio_addr_decode #(
    .NSLV     (NSLV),
    .IW       (IW),
    .SLOT_TAG (SLOT_TAG)
  ) u_decode (
    .tag    (cpu_addr[31:28]),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  assign ack_sel = slv_ack[idx_reg];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    sel_next   = sel_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
`ifdef MIO_BUS_TIMEOUT_EN
    wait_next  = wait_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cpu_req) begin
          if (dec_hit) begin
            idx_next   = dec_idx;
            sel_next   = dec_onehot;
            we_next    = cpu_we;
            addr_next  = cpu_addr[AW+1:2];
            wdata_next = cpu_wdata;
            state_next = ACCESS;
`ifdef MIO_BUS_TIMEOUT_EN
            wait_next  = 8'd0;
`endif
          end else begin
            rdata_next = '0;
            err_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          rdata_next = we_reg ? '0 : slv_rdata[DW*idx_reg +: DW];
          err_next   = 1'b0;
          sel_next   = '0;
          we_next    = 1'b0;
          state_next = RESP;
        end
`ifdef MIO_BUS_TIMEOUT_EN
        else if (wait_reg == 8'(TIMEOUT_CYC - 1)) begin
          rdata_next = '0;
          err_next   = 1'b1;
          sel_next   = '0;
          we_next    = 1'b0;
          state_next = RESP;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
`ifdef MIO_BUS_TIMEOUT_EN
      wait_reg  <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
`ifdef MIO_BUS_TIMEOUT_EN
      wait_reg  <= wait_next;
`endif
    end
  end

  // err_reg may linger from a previous response; qualify it with RESP
  assign cpu_ready = (state_reg == RESP);
  assign cpu_err   = cpu_ready & err_reg;
  assign cpu_rdata = rdata_reg;
  assign slv_sel   = sel_reg;
  assign slv_we    = we_reg;
  assign slv_addr  = addr_reg;
  assign slv_wdata = wdata_reg;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl: expected responses are queued at request
// time and compared when cpu_ready pulses. Timeout case runs under MIO_BUS_TIMEOUT_EN.
module tb_mio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  int           txn = 0;

  logic         req = 1'b0, we = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [31:0]  rdata;
  logic         ready, err;
  logic [3:0]   sel;
  logic         swe;
  logic [12:0]  saddr;
  logic [31:0]  swdata;
  logic [127:0] srdata = '0;
  logic [3:0]   ack = '0;

  logic         req_b = 1'b0;
  logic [31:0]  addr_b = '0;
  logic [31:0]  rdata_b;
  logic         ready_b, err_b;
  logic [3:0]   sel_b;
  logic         swe_b;
  logic [12:0]  saddr_b;
  logic [31:0]  swdata_b;
  logic [127:0] srdata_b = '0;
  logic [3:0]   ack_b = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  logic [31:0] last_rdata = '0;

  mio_bus_ctrl u_dut (
    .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_rdata(rdata), .cpu_ready(ready), .cpu_err(err),
    .slv_sel(sel), .slv_we(swe), .slv_addr(saddr), .slv_wdata(swdata),
    .slv_rdata(srdata), .slv_ack(ack)
  );

  mio_bus_ctrl #(.SLOT_TAG(16'h00d0)) u_dup (
    .clk(clk), .rst(rst), .cpu_req(req_b), .cpu_we(1'b0), .cpu_addr(addr_b),
    .cpu_wdata(32'h0), .cpu_rdata(rdata_b), .cpu_ready(ready_b), .cpu_err(err_b),
    .slv_sel(sel_b), .slv_we(swe_b), .slv_addr(saddr_b), .slv_wdata(swdata_b),
    .slv_rdata(srdata_b), .slv_ack(ack_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ready) begin
      if (q.size() == 0) begin
        check_val("spurious_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        txn++;
        $display("txn %0d: rdata=%h err=%b cyc=%0d", txn, rdata, err, cyc);
        check_val("rdata", rdata, e.rdata);
        check_val("err", {31'd0, err}, {31'd0, e.err});
        check_val("latency", cyc, e.cyc);
      end
    end else if (rst) begin
      check_val("err_idle", {31'd0, err}, 32'd0);
    end
  end

  task automatic run_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int waits, input logic [31:0] sdata, input logic [3:0] esel);
    exp_t e;
    int   c0;
    @(negedge clk);
    c0    = cyc;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    for (int i = 0; i < 4; i++) srdata[32*i +: 32] = esel[i] ? sdata : ~sdata;
    e.rdata = (esel == 4'd0 || w) ? 32'd0 : sdata;
    e.err   = (esel == 4'd0);
    e.cyc   = c0 + ((esel == 4'd0) ? 1 : 2 + waits);
    q.push_back(e);
    @(negedge clk);
    check_val("sel_first", {28'd0, sel}, {28'd0, esel});
    if (esel != 4'd0) begin
      check_val("slv_addr", {19'd0, saddr}, {19'd0, a[14:2]});
      for (int k = 0; k <= waits; k++) begin
        if (k > 0) @(negedge clk);
        check_val("sel_hold", {28'd0, sel}, {28'd0, esel});
        check_val("slv_we", {31'd0, swe}, {31'd0, w});
        if (w) check_val("slv_wdata", swdata, d);
        check_val("rdata_hold", rdata, last_rdata);
        if (k == waits) ack = esel;
      end
      @(negedge clk);
      ack = '0;
      check_val("sel_resp", {28'd0, sel}, 32'd0);
    end
    req = 1'b0;
    last_rdata = e.rdata;
    @(negedge clk);
    check_val("sel_idle", {28'd0, sel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #12;
    check_val("rst_sel", {28'd0, sel}, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_we", {31'd0, swe}, 32'd0);
    check_val("rst_addr", {19'd0, saddr}, 32'd0);
    check_val("rst_wdata", swdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_access(32'h0000_0010, 1'b0, 32'h0,         0, 32'h1234_5678, 4'b0001);
    run_access(32'hE000_0000, 1'b1, 32'hA5A5_0F0F, 3, 32'h5555_AAAA, 4'b0100);
    run_access(32'h8000_0000, 1'b0, 32'h0,         0, 32'h0BAD_0BAD, 4'b0000);
    run_access(32'hD000_0040, 1'b0, 32'h0,         1, 32'hDEAD_BEEF, 4'b0010);
    run_access(32'hF000_0104, 1'b0, 32'h0,         2, 32'h0F0F_1234, 4'b1000);
    run_access(32'h1000_0000, 1'b0, 32'h0,         0, 32'h0,         4'b0000);

    // reset while the slave is still being accessed
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0008; ack = '0;
    @(negedge clk);
    check_val("abort_sel_pre", {28'd0, sel}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("abort_sel_async", {28'd0, sel}, 32'd0);
    check_val("abort_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_rdata = 32'd0;
    repeat (3) @(negedge clk);

    // back-to-back reads with cpu_req held high
    begin
      exp_t e;
      int   c0;
      c0 = cyc;
      req = 1'b1; we = 1'b0; addr = 32'h0000_0020;
      srdata[31:0] = 32'h1111_0001;
      ack = 4'b0001;
      e.rdata = 32'h1111_0001; e.err = 1'b0; e.cyc = c0 + 2; q.push_back(e);
      e.rdata = 32'h2222_0002; e.err = 1'b0; e.cyc = c0 + 5; q.push_back(e);
      @(negedge clk);
      check_val("b2b_sel1", {28'd0, sel}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check_val("b2b_idle_sel", {28'd0, sel}, 32'd0);
      srdata[31:0] = 32'h2222_0002;
      @(negedge clk);
      check_val("b2b_sel2", {28'd0, sel}, 32'd1);
      @(negedge clk);
      req = 1'b0; ack = '0;
      last_rdata = 32'h2222_0002;
      @(negedge clk);
    end

    // duplicate tags: slot 0 wins, slot 3 ack is ignored
    @(negedge clk);
    req_b = 1'b1; addr_b = 32'h0000_0000;
    srdata_b = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_0000};
    @(negedge clk);
    check_val("dup_sel", {28'd0, sel_b}, 32'd1);
    ack_b = 4'b1000;
    repeat (2) begin
      @(negedge clk);
      check_val("dup_ignore_ready", {31'd0, ready_b}, 32'd0);
      check_val("dup_sel_hold", {28'd0, sel_b}, 32'd1);
    end
    ack_b = 4'b0001;
    @(negedge clk);
    ack_b = '0;
    req_b = 1'b0;
    $display("txn dup: rdata=%h err=%b ready=%b", rdata_b, err_b, ready_b);
    check_val("dup_ready", {31'd0, ready_b}, 32'd1);
    check_val("dup_rdata", rdata_b, 32'hCAFE_0000);
    check_val("dup_err", {31'd0, err_b}, 32'd0);

`ifdef MIO_BUS_TIMEOUT_EN
    // slave never acks: error response 16 cycles after select
    begin
      exp_t e;
      int   c0;
      @(negedge clk);
      c0 = cyc;
      req = 1'b1; we = 1'b0; addr = 32'hF000_0000; ack = '0;
      e.rdata = 32'd0; e.err = 1'b1; e.cyc = c0 + 17; q.push_back(e);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        check_val("to_sel_hold", {28'd0, sel}, 32'h8);
      end
      @(negedge clk);
      req = 1'b0;
      check_val("to_sel_drop", {28'd0, sel}, 32'd0);
      @(negedge clk);
      // ack in the final allowed cycle completes normally
      c0 = cyc;
      req = 1'b1; addr = 32'hF000_0000;
      srdata[127:96] = 32'h7777_1616;
      e.rdata = 32'h7777_1616; e.err = 1'b0; e.cyc = c0 + 17; q.push_back(e);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k == 16) ack = 4'b1000;
      end
      @(negedge clk);
      ack = '0; req = 1'b0;
      @(negedge clk);
    end
`endif

    repeat (4) @(negedge clk);
    check_val("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
